vram_host_writer: RTL and testbench

// - Host-side writer for the tile-renderer VRAMs: drives the write ports (port A) of char_ram,

---
 rtl/vram_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 51 +++++
 rtl/vram_host_writer.sv | 165 ++++++++++++++++
 tb/tb_vram_host_writer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared codes, command layout and state encodings for vram_host_writer
package vram_pkg;

  localparam int DATA_W   = 16;
  localparam int TGT_W    = 2;
  localparam int PAL_AW   = 10;
  localparam int LEN_LSB  = 0;
  localparam int DATA_LSB = 12;
  localparam int ADDR_LSB = 28;
  localparam int TGT_LSB  = 40;
  localparam int OP_BIT   = 42;
  localparam int CMD_W    = 43;

  typedef enum logic [1:0] {
    TGT_CHAR = 2'd0,
    TGT_CDAT = 2'd1,
    TGT_PAL  = 2'd2,
    TGT_RSVD = 2'd3
  } tgt_e;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_FILL  = 1'b1
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock command FIFO; head entry read straight from the register array
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == DEPTH[AW:0]);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign rd_data   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vram_host_writer.sv
// rtl/vram_host_writer.sv - queues host write/fill commands and replays them as VRAM port-A strobes
// Optional VRAM_VBLANK_GATE_EN: pop and strobe only while vblank is high.
module vram_host_writer
  import vram_pkg::*;
#(
  parameter int FIFO_AW = 2,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [1:0]        cmd_target,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [15:0]       cmd_data,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              vblank,
  output logic              char_ena,
  output logic              char_wr,
  output logic [ADDR_W-1:0] char_addr,
  output logic [7:0]        char_din,
  output logic              cdat_ena,
  output logic              cdat_wr,
  output logic [ADDR_W-1:0] cdat_addr,
  output logic [7:0]        cdat_din,
  output logic              pal_ena,
  output logic              pal_wr,
  output logic [9:0]        pal_addr,
  output logic [15:0]       pal_din,
  output logic              busy,
  output logic              err
);

  localparam int F_DATA = ADDR_W;
  localparam int F_ADDR = ADDR_W + DATA_W;
  localparam int F_TGT  = 2 * ADDR_W + DATA_W;
  localparam int F_OP   = F_TGT + TGT_W;
  localparam int W_CMD  = F_OP + 1;

  logic [W_CMD-1:0]  w_wr_cmd;
  logic [W_CMD-1:0]  w_rd_cmd;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_gate;
  logic              w_strobe;
  logic              w_adv;
  state_e            r_state;
  state_e            w_state_nxt;
  tgt_e              r_cur_tgt;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [15:0]       r_cur_data;
  logic [ADDR_W-1:0] r_rem;
  logic              r_char_str;
  logic              r_cdat_str;
  logic              r_pal_str;
  logic              r_err;

  assign cmd_ready = !w_full && !rst;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_wr_cmd  = {cmd_op, cmd_target, cmd_addr, cmd_data, cmd_len};

  sync_fifo #(.WIDTH(W_CMD), .AW(FIFO_AW)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (w_wr_cmd),
    .pop     (w_pop),
    .rd_data (w_rd_cmd),
    .full    (w_full),
    .empty   (w_empty)
  );

`ifdef VRAM_VBLANK_GATE_EN
  assign w_gate = vblank;
`else
  logic w_unused_vblank;
  assign w_unused_vblank = vblank;
  assign w_gate = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_strobe    = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && w_gate) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A closed gate freezes address and remaining count so the fill resumes in place.
        if (w_gate) begin
          w_strobe = 1'b1;
          if (r_rem == '0) w_state_nxt = ST_IDLE;
          else             w_adv       = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cur_tgt  <= TGT_CHAR;
      r_cur_addr <= '0;
      r_cur_data <= '0;
      r_rem      <= '0;
      r_err      <= 1'b0;
      r_char_str <= 1'b0;
      r_cdat_str <= 1'b0;
      r_pal_str  <= 1'b0;
      char_addr  <= '0;
      char_din   <= '0;
      cdat_addr  <= '0;
      cdat_din   <= '0;
      pal_addr   <= '0;
      pal_din    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_cur_tgt  <= tgt_e'(w_rd_cmd[F_TGT +: TGT_W]);
        r_cur_addr <= w_rd_cmd[F_ADDR +: ADDR_W];
        r_cur_data <= w_rd_cmd[F_DATA +: DATA_W];
        r_rem      <= (w_rd_cmd[F_OP] == OP_FILL) ? w_rd_cmd[ADDR_W-1:0] : '0;
        if (tgt_e'(w_rd_cmd[F_TGT +: TGT_W]) == TGT_RSVD) r_err <= 1'b1;
      end else if (w_adv) begin
        r_cur_addr <= r_cur_addr + ADDR_W'(1);
        r_rem      <= r_rem - ADDR_W'(1);
      end
      r_char_str <= w_strobe && (r_cur_tgt == TGT_CHAR);
      r_cdat_str <= w_strobe && (r_cur_tgt == TGT_CDAT);
      r_pal_str  <= w_strobe && (r_cur_tgt == TGT_PAL);
      if (w_strobe && r_cur_tgt == TGT_CHAR) begin
        char_addr <= r_cur_addr;
        char_din  <= r_cur_data[7:0];
      end
      if (w_strobe && r_cur_tgt == TGT_CDAT) begin
        cdat_addr <= r_cur_addr;
        cdat_din  <= r_cur_data[7:0];
      end
      if (w_strobe && r_cur_tgt == TGT_PAL) begin
        pal_addr <= r_cur_addr[PAL_AW-1:0];
        pal_din  <= r_cur_data;
      end
    end
  end

  assign char_ena = r_char_str;
  assign char_wr  = r_char_str;
  assign cdat_ena = r_cdat_str;
  assign cdat_wr  = r_cdat_str;
  assign pal_ena  = r_pal_str;
  assign pal_wr   = r_pal_str;
  assign err      = r_err;
  // Counting the strobe registers keeps busy high through the last visible write.
  assign busy     = !w_empty || (r_state != ST_IDLE) || r_char_str || r_cdat_str || r_pal_str;

endmodule

// File: tb/tb_vram_host_writer.sv
// tb/tb_vram_host_writer.sv - directed self-checking bench for vram_host_writer
module tb_vram_host_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [1:0]  cmd_target = 2'd0;
  logic [11:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic [11:0] cmd_len = '0;
  logic        vblank = 1'b1;
  logic        char_ena, char_wr, cdat_ena, cdat_wr, pal_ena, pal_wr;
  logic [11:0] char_addr, cdat_addr;
  logic [7:0]  char_din, cdat_din;
  logic [9:0]  pal_addr;
  logic [15:0] pal_din;
  logic        busy, err;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] ch_a[$], cd_a[$], pl_a[$];
  logic [15:0] ch_d[$], cd_d[$], pl_d[$];
  int          ch_c[$], cd_c[$], pl_c[$];
  logic        bz[$];
  int          wr_mis;

  vram_host_writer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_target(cmd_target), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_len(cmd_len), .vblank(vblank),
    .char_ena(char_ena), .char_wr(char_wr), .char_addr(char_addr), .char_din(char_din),
    .cdat_ena(cdat_ena), .cdat_wr(cdat_wr), .cdat_addr(cdat_addr), .cdat_din(cdat_din),
    .pal_ena(pal_ena), .pal_wr(pal_wr), .pal_addr(pal_addr), .pal_din(pal_din),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the interval right after the accepting edge.
  task automatic send_cmd(input logic op, input logic [1:0] tgt, input logic [11:0] addr,
                          input logic [15:0] data, input logic [11:0] len);
    logic ok, w;
    cmd_op = op; cmd_target = tgt; cmd_addr = addr; cmd_data = data; cmd_len = len;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      w = cmd_ready;
      tick();
      if (w) ok = 1'b1;
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout: got no accept, need accept within 60 cycles");
    end
  endtask

  // Index 0 is the interval the task is called in.
  task automatic collect(input int n);
    ch_a.delete(); ch_d.delete(); ch_c.delete();
    cd_a.delete(); cd_d.delete(); cd_c.delete();
    pl_a.delete(); pl_d.delete(); pl_c.delete();
    bz.delete();
    wr_mis = 0;
    for (int i = 0; i < n; i++) begin
      if (char_ena) begin ch_a.push_back(char_addr); ch_d.push_back({8'h00, char_din}); ch_c.push_back(i); end
      if (cdat_ena) begin cd_a.push_back(cdat_addr); cd_d.push_back({8'h00, cdat_din}); cd_c.push_back(i); end
      if (pal_ena)  begin pl_a.push_back({2'b00, pal_addr}); pl_d.push_back(pal_din); pl_c.push_back(i); end
      if (char_ena !== char_wr || cdat_ena !== cdat_wr || pal_ena !== pal_wr) wr_mis++;
      bz.push_back(busy);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if ({char_ena, cdat_ena, pal_ena} !== 3'b000) begin n_err++; $display("FAIL reset_ena: got %b need 000", {char_ena, cdat_ena, pal_ena}); end
    n_cmp++; if ({busy, err} !== 2'b00) begin n_err++; $display("FAIL reset_busy_err: got %b need 00", {busy, err}); end
    n_cmp++; if ({char_addr, pal_din} !== 28'h0) begin n_err++; $display("FAIL reset_addr_din: got %h need 0", {char_addr, pal_din}); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low: got %b need 0", cmd_ready); end
    rst = 1'b0;
    tick();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %b need 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    send_cmd(1'b0, 2'd0, 12'h041, 16'h005A, 12'h0);
    collect(8);
    n_cmp++; if (ch_a.size() != 1) begin n_err++; $display("FAIL single_count: got %0d need 1", ch_a.size()); end
    if (ch_a.size() > 0) begin
      n_cmp++; if (ch_c[0] != 2) begin n_err++; $display("FAIL single_latency: got %0d need 2", ch_c[0]); end
      n_cmp++; if (ch_a[0] !== 12'h041) begin n_err++; $display("FAIL single_addr: got %h need 041", ch_a[0]); end
      n_cmp++; if (ch_d[0] !== 16'h005A) begin n_err++; $display("FAIL single_din: got %h need 005a", ch_d[0]); end
    end
    n_cmp++; if (cd_a.size() + pl_a.size() != 0) begin n_err++; $display("FAIL single_other_ports: got %0d need 0", cd_a.size() + pl_a.size()); end
    n_cmp++; if (wr_mis != 0) begin n_err++; $display("FAIL single_ena_wr: got %0d need 0", wr_mis); end
  endtask

  task automatic test_fill_pal();
    logic [11:0] exp_a[4];
    exp_a[0] = 12'h3FE; exp_a[1] = 12'h3FF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
    send_cmd(1'b1, 2'd2, 12'h3FE, 16'hBEEF, 12'd3);
    collect(10);
    n_cmp++; if (pl_a.size() != 4) begin n_err++; $display("FAIL fill_count: got %0d need 4", pl_a.size()); end
    for (int i = 0; i < 4 && i < pl_a.size(); i++) begin
      n_cmp++;
      if (pl_a[i] !== exp_a[i] || pl_d[i] !== 16'hBEEF || pl_c[i] != 2 + i) begin
        n_err++;
        $display("FAIL fill_strobe%0d: got addr %h din %h cyc %0d need addr %h din beef cyc %0d",
                 i, pl_a[i], pl_d[i], pl_c[i], exp_a[i], 2 + i);
      end
    end
    n_cmp++; if (bz[5] !== 1'b1 || bz[6] !== 1'b0) begin n_err++; $display("FAIL fill_busy_drop: got %b%b need 10", bz[5], bz[6]); end
    n_cmp++; if (ch_a.size() + cd_a.size() != 0) begin n_err++; $display("FAIL fill_other_ports: got %0d need 0", ch_a.size() + cd_a.size()); end
  endtask

  task automatic test_back_to_back();
    int  acc;
    logic w, rdy_end;
    acc = 0;
    send_cmd(1'b1, 2'd0, 12'hFFE, 16'h0042, 12'd40);
    fork
      collect(80);
      begin
        for (int k = 0; k < 12; k++) begin
          cmd_op = 1'b0; cmd_target = 2'd1; cmd_addr = 12'h010 + 12'(acc);
          cmd_data = 16'h00C0 + 16'(acc); cmd_len = 12'h0;
          cmd_valid = 1'b1;
          w = cmd_ready;
          tick();
          if (w) acc++;
        end
        rdy_end = cmd_ready;
        cmd_valid = 1'b0;
      end
    join
    n_cmp++; if (acc != 4) begin n_err++; $display("FAIL b2b_accepts: got %0d need 4", acc); end
    n_cmp++; if (rdy_end !== 1'b0) begin n_err++; $display("FAIL b2b_ready_low: got %b need 0", rdy_end); end
    n_cmp++; if (ch_a.size() != 41) begin n_err++; $display("FAIL b2b_fill_count: got %0d need 41", ch_a.size()); end
    if (ch_a.size() == 41) begin
      n_cmp++; if (ch_a[0] !== 12'hFFE || ch_a[2] !== 12'h000 || ch_a[40] !== 12'h026) begin
        n_err++; $display("FAIL b2b_fill_wrap: got %h %h %h need ffe 000 026", ch_a[0], ch_a[2], ch_a[40]); end
      n_cmp++; if (ch_c[40] - ch_c[0] != 40) begin n_err++; $display("FAIL b2b_fill_rate: got %0d need 40", ch_c[40] - ch_c[0]); end
    end
    n_cmp++; if (cd_a.size() != 4) begin n_err++; $display("FAIL b2b_queued_count: got %0d need 4", cd_a.size()); end
    for (int i = 0; i < 4 && i < cd_a.size(); i++) begin
      n_cmp++;
      if (cd_a[i] !== 12'h010 + 12'(i) || cd_d[i] !== 16'h00C0 + 16'(i)) begin
        n_err++; $display("FAIL b2b_queued%0d: got %h/%h need %h/%h", i, cd_a[i], cd_d[i], 12'h010 + 12'(i), 16'h00C0 + 16'(i));
      end
    end
    if (cd_a.size() == 4 && ch_a.size() == 41) begin
      n_cmp++; if (cd_c[0] != ch_c[40] + 2 || cd_c[3] - cd_c[0] != 6) begin
        n_err++; $display("FAIL b2b_single_rate: got first %0d span %0d need %0d span 6", cd_c[0], cd_c[3] - cd_c[0], ch_c[40] + 2); end
    end
  endtask

  task automatic test_target3();
    send_cmd(1'b1, 2'd3, 12'h100, 16'h1234, 12'd2);
    collect(8);
    n_cmp++; if (ch_a.size() + cd_a.size() + pl_a.size() != 0) begin
      n_err++; $display("FAIL rsvd_strobes: got %0d need 0", ch_a.size() + cd_a.size() + pl_a.size()); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL rsvd_err_set: got %b need 1", err); end
    send_cmd(1'b0, 2'd0, 12'h123, 16'h0077, 12'h0);
    collect(6);
    n_cmp++; if (ch_a.size() != 1 || (ch_a.size() > 0 && (ch_a[0] !== 12'h123 || ch_d[0] !== 16'h0077))) begin
      n_err++; $display("FAIL rsvd_next_cmd: got count %0d need 1 write at 123 data 77", ch_a.size()); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL rsvd_err_sticky: got %b need 1", err); end
  endtask

  task automatic test_reset_mid_fill();
    int cnt;
    logic [11:0] last;
    int post;
    cnt = 0; last = '0;
    send_cmd(1'b1, 2'd0, 12'h200, 16'h0033, 12'd100);
    for (int k = 0; k < 40; k++) begin
      if (char_ena) begin cnt++; last = char_addr; end
      if (cnt == 10) break;
      tick();
    end
    n_cmp++; if (cnt != 10 || last !== 12'h209) begin n_err++; $display("FAIL midfill_10th: got cnt %0d addr %h need 10 209", cnt, last); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({char_ena, cdat_ena, pal_ena, busy} !== 4'b0000) begin
      n_err++; $display("FAIL midfill_reset_outs: got %b need 0000", {char_ena, cdat_ena, pal_ena, busy}); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL midfill_err_cleared: got %b need 0", err); end
    rst = 1'b0;
    post = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (char_ena || busy) post++;
    end
    n_cmp++; if (post != 0) begin n_err++; $display("FAIL midfill_no_resume: got %0d active cycles need 0", post); end
    send_cmd(1'b0, 2'd0, 12'h005, 16'h00A5, 12'h0);
    collect(6);
    n_cmp++; if (ch_a.size() != 1 || (ch_a.size() > 0 && (ch_a[0] !== 12'h005 || ch_d[0] !== 16'h00A5 || ch_c[0] != 2))) begin
      n_err++; $display("FAIL midfill_fresh_write: got count %0d need 1 write at 005 data a5", ch_a.size()); end
  endtask

`ifdef VRAM_VBLANK_GATE_EN
  task automatic test_vblank_gate();
    logic [11:0] q[$];
    int phase, low, at_resume;
    phase = 0; low = 0; at_resume = -1;
    vblank = 1'b1;
    send_cmd(1'b1, 2'd0, 12'h0F0, 16'h0011, 12'd7);
    for (int k = 0; k < 30; k++) begin
      if (char_ena) q.push_back(char_addr);
      if (phase == 0 && q.size() == 3) begin
        vblank = 1'b0; phase = 1;
      end else if (phase == 1) begin
        low++;
        if (low == 5) begin at_resume = q.size(); vblank = 1'b1; phase = 2; end
      end
      tick();
    end
    n_cmp++; if (at_resume != 3) begin n_err++; $display("FAIL vblank_pause: got %0d need 3", at_resume); end
    n_cmp++; if (q.size() != 8) begin n_err++; $display("FAIL vblank_total: got %0d need 8", q.size()); end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      n_cmp++; if (q[i] !== 12'h0F0 + 12'(i)) begin n_err++; $display("FAIL vblank_addr%0d: got %h need %h", i, q[i], 12'h0F0 + 12'(i)); end
    end
  endtask
`else
  task automatic test_vblank_gate();
    vblank = 1'b0;
    send_cmd(1'b0, 2'd0, 12'h3C0, 16'h0009, 12'h0);
    collect(6);
    vblank = 1'b1;
    n_cmp++; if (ch_a.size() != 1 || (ch_a.size() > 0 && (ch_a[0] !== 12'h3C0 || ch_c[0] != 2))) begin
      n_err++; $display("FAIL vblank_ignored: got count %0d need 1 write at 3c0", ch_a.size()); end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_single_write();
    test_fill_pal();
    test_back_to_back();
    test_target3();
    test_reset_mid_fill();
    test_vblank_gate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
